uart_tx: RTL and testbench

UART transmitter, the mirror of the UART RX path. It accepts a parallel byte with a valid strobe, then drives a serial frame on tx_out at one bit per `prescale` clock cycles. The frame is start bit, data LSB first, optional parity, then stop. It sits between the TX-side FIFO/sync logic and the serial pad.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_bit_timer.sv | 32 +++
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART states, line levels and parity encodings
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - counts 0..P-1 while run, pulses bit_done on P-1
module uart_tx_bit_timer #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  run,
    output logic                  bit_done
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // prescale is never 0 while run is high, so P-1 does not wrap
    assign bit_done = run && (cnt_q == (prescale - PRESCALE_W'(1)));

    always_comb begin
        cnt_d = cnt_q + PRESCALE_W'(1);
        if (!run || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter; UART_TX_TWO_STOP_EN adds a stop2 input
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] prescale,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  stop2,
`endif
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_q, par_d;
    logic                  pen_q, pen_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_done;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop2_q, stop2_d;
    logic                  stop_idx_q, stop_idx_d;
`endif

    uart_tx_bit_timer #(
        .PRESCALE_W(PRESCALE_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .prescale(presc_q),
        .run     (state_q != IDLE),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        presc_d   = presc_q;
        par_d     = par_q;
        pen_d     = pen_q;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    shift_d   = p_data;
                    bit_cnt_d = '0;
                    presc_d   = (prescale == '0) ? PRESCALE_W'(1) : prescale;
                    par_d     = (^p_data) ^ (par_typ != PAR_EVEN);
                    pen_d     = par_en;
`ifdef UART_TX_TWO_STOP_EN
                    stop2_d    = stop2;
                    stop_idx_d = 1'b0;
`endif
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so tx_out is a clean register
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_q;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            presc_q   <= '0;
            par_q     <= 1'b0;
            pen_q     <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            presc_q   <= presc_d;
            par_q     <= par_d;
            pen_q     <= pen_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
`endif
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (frame scoreboard + table)
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       tx_out;
    logic       busy;
`ifdef UART_TX_TWO_STOP_EN
    logic       stop2;
`endif

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_WIDTH(8),
        .PRESCALE_W(6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .prescale  (prescale),
`ifdef UART_TX_TWO_STOP_EN
        .stop2     (stop2),
`endif
        .tx_out    (tx_out),
        .busy      (busy)
    );

    typedef struct {
        logic [11:0] bits;   // bit i = i-th bit on the line
        int          nbits;
        int          p;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        logic [5:0]  presc;
        int          p;
        logic [11:0] bits;
        int          nbits;
    } vec_t;

    exp_t sb[$];
    int   starts[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   fr = 0;
    logic mon_en = 1'b0;
    logic mon_busy = 1'b0;
    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                        input logic [5:0] ps, input logic s2);
        @(negedge clk);
        p_data     = d;
        par_en     = pen;
        par_typ    = ptyp;
        prescale   = ps;
`ifdef UART_TX_TWO_STOP_EN
        stop2      = s2;
`else
        if (s2) $display("note: stop2 ignored in this build");
`endif
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic push(input logic [11:0] bits, input int nbits, input int p);
        exp_t e;
        e.bits  = bits;
        e.nbits = nbits;
        e.p     = p;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: a falling line starts a frame, checked bit by bit against the scoreboard
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (mon_en && tx_out == 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_frame", sb.size(), 32'd1);
                    for (int k = 0; k < 5000 && tx_out == 1'b0; k++) @(negedge clk);
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < e.nbits; i++) begin
                        ok = 1'b1;
                        for (int c = 0; c < e.p; c++) begin
                            if (i != 0 || c != 0) @(negedge clk);
                            if (tx_out !== e.bits[i] || busy !== 1'b1) ok = 1'b0;
                        end
                        chk($sformatf("frame%0d_bit%0d_exp%0b", fr, i, e.bits[i]), ok, 32'd1);
                    end
                    @(negedge clk);
                    chk($sformatf("frame%0d_end_busy_tx", fr), {busy, tx_out}, 32'b01);
                    fr++;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        vecs[0] = '{8'hA3, 1'b0, 1'b0, 6'd8, 8, 12'h346, 10};
        vecs[1] = '{8'hA3, 1'b1, 1'b0, 6'd4, 4, 12'h546, 11};
        vecs[2] = '{8'hA3, 1'b1, 1'b1, 6'd4, 4, 12'h746, 11};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 6'd0, 1, 12'h2AA, 10};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 6'd1, 1, 12'h2AA, 10};

        rst = 1'b1; p_data = '0; data_valid = 1'b0; par_en = 1'b0;
        par_typ = 1'b0; prescale = 6'd8;
`ifdef UART_TX_TWO_STOP_EN
        stop2 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_tx_out", tx_out, 32'd1);
        chk("reset_busy", busy, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 5; v++) begin
            push(vecs[v].bits, vecs[v].nbits, vecs[v].p);
            send(vecs[v].data, vecs[v].pen, vecs[v].ptyp, vecs[v].presc, 1'b0);
            wait_done($sformatf("vec%0d", v));
        end

        // data_valid held high: back-to-back frames with one idle cycle between
        starts.delete();
        @(negedge clk);
        p_data = 8'h55; par_en = 1'b0; prescale = 6'd1; data_valid = 1'b1;
        for (int k = 0; k < 3; k++) push(12'h2AA, 10, 1);
        for (int n = 0; n < 3000 && sb.size() != 0; n++) @(negedge clk);
        data_valid = 1'b0;
        wait_done("hold");
        chk("hold_frames", starts.size(), 32'd3);
        if (starts.size() == 3) begin
            chk("hold_gap0", starts[1] - starts[0], 32'd11);
            chk("hold_gap1", starts[2] - starts[1], 32'd11);
        end

        // Mid-frame input changes must not disturb the frame or queue another
        starts.delete();
        push(12'h346, 10, 8);
        send(8'hA3, 1'b0, 1'b0, 6'd8, 1'b0);
        repeat (19) @(negedge clk);
        p_data = 8'hFF; prescale = 6'd2; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        wait_done("midframe");
        repeat (30) @(negedge clk);
        chk("no_second_frame", starts.size(), 32'd1);

        // Reset mid-frame aborts, then a clean frame follows
        mon_en = 1'b0;
        send(8'hA3, 1'b0, 1'b0, 6'd8, 1'b0);
        repeat (29) @(negedge clk);
        chk("pre_reset_busy", busy, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx_out", tx_out, 32'd1);
        chk("abort_busy", busy, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {busy, tx_out}, 32'b01);
        mon_en = 1'b1;
        push(12'h21E, 10, 8);
        send(8'h0F, 1'b0, 1'b0, 6'd8, 1'b0);
        wait_done("after_reset");

`ifdef UART_TX_TWO_STOP_EN
        push(12'h600, 11, 4);
        send(8'h00, 1'b0, 1'b0, 6'd4, 1'b1);
        wait_done("two_stop");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
